// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the stack buffer:
//   stack_op_e   - decoded operation (IDLE / PUSH / POP / SWAP)
//   count_width  - width needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package stack_pkg;

    // The encoding matches {pop, push}, so the decode is a direct cast
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PUSH = 2'b01,
        POP  = 2'b10,
        SWAP = 2'b11
    } stack_op_e;

    // Occupancy runs 0..depth inclusive, so one more value than the depth
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// -----------------------------------------------------------------------------
// stack_regfile
// Entry storage for the stack buffer. Contents are not reset.
// Ports:
//   clock    - write clock (rising edge)
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - asynchronous read address
//   o_rdata  - asynchronous read data
// -----------------------------------------------------------------------------
module stack_regfile
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Single synchronous write port; entries hold their value when not written
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_buffer.sv
// -----------------------------------------------------------------------------
// stack_buffer
// LIFO buffer with registered pop data, combinational top-of-stack peek and
// sticky overflow/underflow flags.
// Ports:
//   clock      - clock, rising edge
//   reset      - asynchronous active-low reset
//   push/pop   - operation requests (both together = swap)
//   clear      - synchronous empty, highest priority
//   err_clear  - synchronous clear of the sticky error flags
//   inp_data   - push data
//   out_data   - registered popped data, qualified by out_valid (1-cycle pulse)
//   top_data   - combinational peek of the top entry (zero when empty)
//   count      - occupancy 0..DEPTH
//   stack_empty/stack_full - occupancy decodes
//   overflow/underflow     - sticky error flags
// -----------------------------------------------------------------------------
module stack_buffer
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int COUNT_WIDTH = count_width(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic                   err_clear,
    input  logic [DATA_WIDTH-1:0]  inp_data,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  top_data,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] C_ZERO  = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] C_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] C_DEPTH = COUNT_WIDTH'(DEPTH);

    logic [COUNT_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic                   r_out_valid;
    logic                   r_overflow;
    logic                   r_underflow;

    stack_op_e              w_op;
    logic                   w_empty;
    logic                   w_full;
    logic [ADDR_WIDTH-1:0]  w_top_addr;
    logic [DATA_WIDTH-1:0]  w_rdata;
    logic [COUNT_WIDTH-1:0] w_next_count;
    logic                   w_we;
    logic [ADDR_WIDTH-1:0]  w_waddr;
    logic                   w_load_out;
    logic [DATA_WIDTH-1:0]  w_next_out;
    logic                   w_ovf_set;
    logic                   w_unf_set;

    assign w_op    = stack_op_e'({pop, push});
    assign w_empty = (r_count == C_ZERO);
    assign w_full  = (r_count == C_DEPTH);

    // Wraps to DEPTH-1 when empty; the read is only used when non-empty
    assign w_top_addr = ADDR_WIDTH'(r_count - C_ONE);

    stack_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (inp_data),
        .i_raddr (w_top_addr),
        .o_rdata (w_rdata)
    );

    // Operation decode: next occupancy, storage write, output load and error events
    always_comb begin
        w_next_count = r_count;
        w_we         = 1'b0;
        w_waddr      = r_count[ADDR_WIDTH-1:0];
        w_load_out   = 1'b0;
        w_next_out   = r_out_data;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        if (clear) begin
            w_next_count = C_ZERO;
        end else begin
            case (w_op)
                PUSH: begin
                    if (!w_full) begin
                        w_we         = 1'b1;
                        w_waddr      = r_count[ADDR_WIDTH-1:0];
                        w_next_count = r_count + C_ONE;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end
                POP: begin
                    if (!w_empty) begin
                        w_load_out   = 1'b1;
                        w_next_out   = w_rdata;
                        w_next_count = r_count - C_ONE;
                    end else begin
                        w_unf_set = 1'b1;
                    end
                end
                SWAP: begin
                    if (!w_empty) begin
                        w_load_out = 1'b1;
                        w_next_out = w_rdata;
                        w_we       = 1'b1;
                        w_waddr    = w_top_addr;
                    end else begin
                        // Empty swap passes the input straight through
                        w_load_out = 1'b1;
                        w_next_out = inp_data;
                    end
                end
                default: begin
                    w_next_count = r_count;
                end
            endcase
        end
    end

    // Occupancy, output data/valid and sticky error flag registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count     <= C_ZERO;
            r_out_data  <= {DATA_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_next_count;
            r_out_valid <= w_load_out;
            if (w_load_out) begin
                r_out_data <= w_next_out;
            end
            // A fresh error wins over err_clear in the same cycle
            r_overflow  <= w_ovf_set | (r_overflow  & ~err_clear);
            r_underflow <= w_unf_set | (r_underflow & ~err_clear);
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign count       = r_count;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign top_data    = w_empty ? {DATA_WIDTH{1'b0}} : w_rdata;

endmodule

// File: tb/tb_stack_buffer.sv
// -----------------------------------------------------------------------------
// tb_stack_buffer
// Self-checking bench for stack_buffer (DATA_WIDTH=8, DEPTH=4): directed
// scenarios followed by random traffic, compared against a queue-based model.
// -----------------------------------------------------------------------------
module tb_stack_buffer;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = 3;

    logic          clock;
    logic          reset;
    logic          push;
    logic          pop;
    logic          clear;
    logic          err_clear;
    logic [DW-1:0] inp_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [DW-1:0] top_data;
    logic [CW-1:0] count;
    logic          stack_empty;
    logic          stack_full;
    logic          overflow;
    logic          underflow;

    int n_total;
    int n_bad;

    // Reference model state
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_out;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;

    stack_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .clear       (clear),
        .err_clear   (err_clear),
        .inp_data    (inp_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .top_data    (top_data),
        .count       (count),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_top();
        if (m_q.size() > 0) return m_q[m_q.size()-1];
        return 8'h00;
    endfunction

    // One clock of stack behaviour, written from the operation rules
    task automatic model_step(input logic p, input logic q, input logic c, input logic e,
                              input logic [DW-1:0] d);
        logic new_ovf;
        logic new_unf;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        m_valid = 1'b0;
        if (c) begin
            m_q.delete();
        end else if (p && !q) begin
            if (m_q.size() < DP) m_q.push_back(d);
            else new_ovf = 1'b1;
        end else if (!p && q) begin
            if (m_q.size() > 0) begin
                m_out   = m_q.pop_back();
                m_valid = 1'b1;
            end else begin
                new_unf = 1'b1;
            end
        end else if (p && q) begin
            if (m_q.size() > 0) begin
                m_out = m_q[m_q.size()-1];
                m_q[m_q.size()-1] = d;
            end else begin
                m_out = d;
            end
            m_valid = 1'b1;
        end
        m_ovf = new_ovf | (m_ovf & ~e);
        m_unf = new_unf | (m_unf & ~e);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check({tag, ".empty"}, 32'(stack_empty), 32'(m_q.size() == 0));
        check({tag, ".full"},  32'(stack_full), 32'(m_q.size() == DP));
        check({tag, ".top"},   32'(top_data), 32'(m_top()));
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".out"},   32'(out_data), 32'(m_out));
        check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
        check({tag, ".unf"},   32'(underflow), 32'(m_unf));
    endtask

    task automatic do_op(input string tag, input logic p, input logic q, input logic c,
                         input logic e, input logic [DW-1:0] d);
        push      = p;
        pop       = q;
        clear     = c;
        err_clear = e;
        inp_data  = d;
        @(posedge clock);
        model_step(p, q, c, e, d);
        #1;
        check_all(tag);
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out   = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Assert reset mid-cycle, check it acts at once, hold a push through it
    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst_count"}, 32'(count), 32'd0);
        check({tag, ".rst_out"},   32'(out_data), 32'd0);
        check({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".rst_flags"}, 32'({overflow, underflow}), 32'd0);
        push     = 1'b1;
        inp_data = 8'h99;
        repeat (2) @(posedge clock);
        #1;
        check({tag, ".rst_hold"}, 32'(count), 32'd0);
        @(negedge clock);
        push  = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        err_clear = 1'b0;
        inp_data  = 8'h00;
        model_reset();
        @(posedge clock);
        apply_reset("init");
        check_all("post_rst");

        // Fill, then overflow
        do_op("fill1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        do_op("fill2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        do_op("fill3", 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        do_op("fill4", 1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
        do_op("ovf",   1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        check("ovf.count_lit", 32'(count), 32'd4);
        check("ovf.flag_lit",  32'(overflow), 32'd1);
        check("ovf.top_lit",   32'(top_data), 32'h44);

        // Drain in LIFO order
        do_op("pop1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pop1.lit", 32'(out_data), 32'h44);
        do_op("pop2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pop2.lit", 32'(out_data), 32'h33);
        do_op("pop3", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pop3.lit", 32'(out_data), 32'h22);
        do_op("pop4", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pop4.lit", 32'(out_data), 32'h11);
        do_op("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("idle.valid_lit", 32'(out_valid), 32'd0);

        // Underflow, then err_clear
        do_op("unf", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("unf.flag_lit", 32'(underflow), 32'd1);
        do_op("eclr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("eclr.flag_lit", 32'({overflow, underflow}), 32'd0);

        // Error in the same cycle as err_clear stays set
        do_op("unf_eclr", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("unf_eclr.lit", 32'(underflow), 32'd1);
        do_op("eclr2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Swap with entries present
        do_op("sw_a", 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        do_op("sw_b", 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        do_op("swap", 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
        check("swap.out_lit", 32'(out_data), 32'h22);
        check("swap.top_lit", 32'(top_data), 32'hAA);
        check("swap.cnt_lit", 32'(count), 32'd2);

        // Swap when full
        do_op("sw_c", 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        do_op("sw_d", 1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
        do_op("swap_full", 1'b1, 1'b1, 1'b0, 1'b0, 8'hBB);

        // Clear keeps out_data and flags, drops valid
        do_op("clear", 1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
        check("clear.out_lit", 32'(out_data), 32'h44);

        // Swap when empty bypasses input
        do_op("swap_empty", 1'b1, 1'b1, 1'b0, 1'b0, 8'h5C);
        check("swap_empty.lit", 32'(out_data), 32'h5C);

        // Reset mid-stream with three entries
        do_op("r_a", 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        do_op("r_b", 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
        do_op("r_c", 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
        apply_reset("mid");
        do_op("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        check("after_rst.lit", 32'(count), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            logic p, q, c, e;
            r = $urandom_range(0, 99);
            p = (r < 40) || (r >= 70 && r < 85);
            q = (r >= 40 && r < 85);
            c = (r >= 85 && r < 88);
            e = ($urandom_range(0, 9) == 0);
            do_op("rnd", p, q, c, e, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
